// File: rtl/bus_arbiter4way16_pkg.sv
// Shared types and helpers for the four-way round-robin bus arbiter.
// Holds the FSM state encoding, parameter defaults and the RR pick function.
package bus_arbiter4way16_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_W_DEF     = 4;

    // Returns {found, index}: first set bit searching from last+1 and wrapping
    // through last. Descending loop so the nearest candidate is written last.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v,
                                           input logic [1:0] last);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req_v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter4way16_mux4way16.sv
// 16-bit four-input data mux that steers the owner's word onto the channel.
module mux4way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] out
);

    always_comb begin
        out = a;
        case (sel)
            2'd0: out = a;
            2'd1: out = b;
            2'd2: out = c;
            2'd3: out = d;
            default: out = a;
        endcase
    end

endmodule

// File: rtl/bus_arbiter4way16.sv
// Round-robin arbiter sharing one 16-bit valid/ready channel among four
// requesters, with bounded bursts of MAX_BURST transfers per grant.
import bus_arbiter4way16_pkg::*;

module bus_arbiter4way16 #(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  sel
);

    state_t           r_state, w_state_nx;
    logic [1:0]       r_sel, w_sel_nx;
    logic [1:0]       r_last, w_last_nx;
    logic [CNT_W-1:0] r_beat, w_beat_nx;

    logic [3:0]       w_own_oh;
    logic             w_xfer;
    logic             w_burst_end;
    logic [2:0]       w_pick_all;
    logic [2:0]       w_pick_oth;

    assign w_own_oh    = 4'b0001 << r_sel;
    assign w_burst_end = (r_beat == CNT_W'(MAX_BURST - 1));
    // Normal pick starts after the last owner; end-of-burst pick excludes it.
    assign w_pick_all  = rr_pick(req, r_last);
    assign w_pick_oth  = rr_pick(req & ~w_own_oh, r_sel);

    // Reset masks the handshake so a reset cycle never completes a transfer.
    assign out_valid = (r_state == ST_GRANT) & req[r_sel] & ~reset;
    assign w_xfer    = out_valid & out_ready;
    assign ack       = {4{w_xfer}} & w_own_oh;
    assign gnt       = (r_state == ST_GRANT) ? w_own_oh : 4'b0000;
    assign sel       = r_sel;

    mux4way16 u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (r_sel),
        .out (y)
    );

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_last_nx  = r_last;
        w_beat_nx  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_all[2]) begin
                    w_state_nx = ST_GRANT;
                    w_sel_nx   = w_pick_all[1:0];
                    w_last_nx  = w_pick_all[1:0];
                    w_beat_nx  = '0;
                end
            end
            ST_GRANT: begin
                if (w_xfer) begin
                    if (w_burst_end) begin
                        w_beat_nx = '0;
                        // No competitor: the same owner simply starts a new burst.
                        if (w_pick_oth[2]) begin
                            w_sel_nx  = w_pick_oth[1:0];
                            w_last_nx = w_pick_oth[1:0];
                        end
                    end else begin
                        w_beat_nx = r_beat + CNT_W'(1);
                    end
                end else if (!req[r_sel]) begin
                    w_beat_nx = '0;
                    if (w_pick_all[2]) begin
                        w_sel_nx  = w_pick_all[1:0];
                        w_last_nx = w_pick_all[1:0];
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_last  <= w_last_nx;
            r_beat  <= w_beat_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter4way16.sv
// Self-checking bench for bus_arbiter4way16: directed scenarios plus random
// traffic, all compared against a transfer-counting reference model.
module tb_bus_arbiter4way16;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] a, b, c, d;
    logic [3:0]  gnt, ack;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  sel;

    int errors = 0;
    int checks = 0;

    // Reference model: owner index (-1 idle), transfers done in this grant,
    // last granted index for RR, and the index the channel mux points at.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = 3;
    int m_sel   = 0;

    bus_arbiter4way16 #(.MAX_BURST(MAXB), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .ack       (ack),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [26:0] exp_outs();
        logic [3:0]  g;
        logic [3:0]  ak;
        logic        ov;
        logic [15:0] yy;
        g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        ov = (m_owner >= 0) && req[m_owner] && !reset;
        ak = (ov && out_ready) ? g : 4'b0000;
        case (m_sel)
            0: yy = a;
            1: yy = b;
            2: yy = c;
            default: yy = d;
        endcase
        return {g, 2'(m_sel), yy, ov, ak};
    endfunction

    function automatic logic [26:0] obs();
        return {gnt, sel, y, out_valid, ack};
    endfunction

    task automatic model_grant(input int p);
        m_owner = p;
        m_beats = 0;
        m_last  = p;
        m_sel   = p;
    endtask

    // Advance one clock; the model consumes the same inputs the DUT sampled.
    task automatic tick();
        int p;
        @(posedge clk);
        if (reset) begin
            m_owner = -1; m_beats = 0; m_last = 3; m_sel = 0;
        end else if (m_owner < 0) begin
            p = pick(req, m_last);
            if (p >= 0) model_grant(p);
        end else if (req[m_owner] && out_ready) begin
            m_beats++;
            if (m_beats == MAXB) begin
                m_beats = 0;
                p = pick(req & ~4'(1 << m_owner), m_owner);
                if (p >= 0) model_grant(p);
            end
        end else if (!req[m_owner]) begin
            p = pick(req, m_last);
            if (p < 0) m_owner = -1;
            else model_grant(p);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
        a = 16'h0a0a; b = 16'h0b0b; c = 16'h0c0c; d = 16'h0d0d;
        tick();
        tick();
        #1;
        if ({gnt, sel, out_valid, ack} !== 11'b0) begin
            errors++; $display("FAIL reset_state: got %b exp %b", {gnt, sel, out_valid, ack}, 11'b0);
        end
        checks++;
        req = 4'b1111; out_ready = 1'b1;
        #1;
        if ({out_valid, ack} !== 5'b0) begin
            errors++; $display("FAIL reset_hold_quiet: got %b exp 0", {out_valid, ack});
        end
        checks++;
        tick();
        reset = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_single();
        int n;
        logic [26:0] e;
        do_reset();
        c = 16'h1234; req = 4'b0100; out_ready = 1'b1;
        #1;
        e = exp_outs();
        if (obs() !== e) begin errors++; $display("FAIL single_idle: got %h exp %h", obs(), e); end
        checks++;
        tick();
        #1;
        if (obs() !== {4'b0100, 2'd2, 16'h1234, 1'b1, 4'b0100}) begin
            errors++; $display("FAIL single_first: got %h exp %h", obs(), {4'b0100, 2'd2, 16'h1234, 1'b1, 4'b0100});
        end
        checks++;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            e = exp_outs();
            if (obs() !== e) begin errors++; $display("FAIL single_model: got %h exp %h", obs(), e); end
            checks++;
            if (ack === 4'b0100) n++;
            tick();
            #1;
        end
        if (n !== 9 || gnt !== 4'b0100) begin
            errors++; $display("FAIL single_regrant: got acks=%0d gnt=%b exp acks=9 gnt=0100", n, gnt);
        end
        checks++;
    endtask

    task automatic test_fair();
        logic [26:0] e;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        a = 16'haaaa; b = 16'hbbbb; c = 16'hcccc; d = 16'hdddd;
        tick();
        for (int i = 0; i < 24; i++) begin
            #1;
            e = exp_outs();
            if (obs() !== e) begin errors++; $display("FAIL fair_model: got %h exp %h", obs(), e); end
            checks++;
            if (ack !== 4'(1 << ((i / MAXB) % 4))) begin
                errors++; $display("FAIL fair_order: beat %0d got %b exp %b", i, ack, 4'(1 << ((i / MAXB) % 4)));
            end
            checks++;
            tick();
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        b = 16'hbeef; req = 4'b0010; out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ({gnt, y, ack} !== {4'b0010, 16'hbeef, 4'b0000}) begin
                errors++; $display("FAIL stall_hold: got %h exp %h", {gnt, y, ack}, {4'b0010, 16'hbeef, 4'b0000});
            end
            checks++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        if (ack !== 4'b0010) begin errors++; $display("FAIL stall_release: got %b exp 0010", ack); end
        checks++;
        tick();
        out_ready = 1'b0;
        #1;
        if (ack !== 4'b0000) begin errors++; $display("FAIL stall_single_ack: got %b exp 0000", ack); end
        checks++;
        tick();
        // Two more beats complete the burst of four begun before the stall.
        out_ready = 1'b1; req = 4'b0011;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (ack === 4'b0010) n++;
            tick();
        end
        if (n !== 2 || gnt !== 4'b0001) begin
            errors++; $display("FAIL stall_beat_count: got acks=%0d gnt=%b exp acks=2 gnt=0001", n, gnt);
        end
        checks++;
    endtask

    task automatic test_withdraw();
        logic [26:0] e;
        do_reset();
        req = 4'b1000; out_ready = 1'b1;
        tick();
        tick();
        tick();
        req = 4'b0001;
        #1;
        if ({out_valid, ack} !== 5'b0) begin errors++; $display("FAIL withdraw_quiet: got %b exp 0", {out_valid, ack}); end
        checks++;
        tick();
        #1;
        if ({gnt, sel, out_valid} !== {4'b0001, 2'd0, 1'b1}) begin
            errors++; $display("FAIL withdraw_handover: got %b exp %b", {gnt, sel, out_valid}, {4'b0001, 2'd0, 1'b1});
        end
        checks++;
        tick();
        req = 4'b0000;
        tick();
        #1;
        e = exp_outs();
        if ({gnt, out_valid} !== 5'b0 || obs() !== e) begin
            errors++; $display("FAIL withdraw_idle: got %h exp %h", obs(), e);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100; out_ready = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1; req = 4'b1111;
        #1;
        if ({out_valid, ack} !== 5'b0) begin errors++; $display("FAIL rstmid_no_ack: got %b exp 0", {out_valid, ack}); end
        checks++;
        tick();
        reset = 1'b0;
        #1;
        if ({gnt, out_valid} !== 5'b0) begin errors++; $display("FAIL rstmid_idle: got %b exp 0", {gnt, out_valid}); end
        checks++;
        tick();
        #1;
        if ({gnt, sel} !== {4'b0001, 2'd0}) begin
            errors++; $display("FAIL rstmid_first_grant: got %b exp %b", {gnt, sel}, {4'b0001, 2'd0});
        end
        checks++;
    endtask

    task automatic test_late();
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        req = 4'b0011;
        #1;
        if (ack !== 4'b0001) begin errors++; $display("FAIL late_fourth_ack: got %b exp 0001", ack); end
        checks++;
        tick();
        #1;
        if ({gnt, out_valid} !== {4'b0010, 1'b1}) begin
            errors++; $display("FAIL late_zero_bubble: got %b exp %b", {gnt, out_valid}, {4'b0010, 1'b1});
        end
        checks++;
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (gnt !== 4'b0001) begin errors++; $display("FAIL late_no_preempt: beat %0d got %b exp 0001", i, gnt); end
            checks++;
            tick();
        end
        #1;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL late_after_burst: got %b exp 0010", gnt); end
        checks++;
    endtask

    task automatic test_random();
        logic [26:0] e;
        logic [3:0]  prev_ack;
        logic [3:0]  r;
        logic [15:0] dat [4];
        do_reset();
        req = 4'b0000; prev_ack = 4'b0000;
        for (int i = 0; i < 4; i++) dat[i] = 16'($urandom);
        for (int t = 0; t < 600; t++) begin
            r = req;
            for (int i = 0; i < 4; i++) begin
                if (prev_ack[i]) begin
                    if ($urandom_range(1, 0) == 1) dat[i] = 16'($urandom);
                    else r[i] = 1'b0;
                end else if (r[i]) begin
                    if ($urandom_range(19, 0) == 0) r[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    r[i] = 1'b1;
                    dat[i] = 16'($urandom);
                end
            end
            req = r;
            a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];
            out_ready = ($urandom_range(3, 0) != 0);
            reset = ($urandom_range(99, 0) == 0);
            #1;
            e = exp_outs();
            if (obs() !== e) begin errors++; $display("FAIL random_model: cycle %0d got %h exp %h", t, obs(), e); end
            checks++;
            prev_ack = e[3:0];
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fair();
        test_stall();
        test_withdraw();
        test_reset_mid();
        test_late();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1);
    end

endmodule
